ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS32 pipeline, fed directly by the ID/EX pipeline register; output feeds the EX/MEM register.
- Combinational ALU for single-cycle ops. Owns the HI/LO registers, a single-cycle multiplier and a 32-iteration restoring divider FSM.
- Drives the ALU-stage forwarding path back to ID/EX.
- Raises a stall request while a divide is in flight; pipeline control holds upstream stages.

---
 rtl/ex_stage.sv | 196 +++++++++++++++++++
 tb/tb_ex_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS32 pipeline.
//   Combinational ALU for single-cycle ops, HI/LO registers, a single-cycle
//   multiplier and a 32-iteration restoring divider. A divide holds the
//   upstream pipeline through stall_req_o until its sign-correction cycle.
// Ports:
//   clk, rst              - clock; synchronous active-high reset
//   alu_op_i              - 5-bit operation code
//   src_data1_i/2_i       - operands A (rs or shamt) and B (rt or imm)
//   write_reg_addr_i/_o   - destination GPR, passed through
//   control_signal_i/_o   - downstream control bits, zeroed while stalling
//   mem_write_data_i/_o   - store data, passed through
//   alu_result_o          - combinational result
//   bpalu_write_reg_en_o  - forwarding-path write enable
//   stall_req_o           - hold ID/EX and earlier stages
`timescale 1ns/1ps
module ex_stage #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned WE_BIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        alu_op_i,
    input  logic [31:0]       src_data1_i,
    input  logic [31:0]       src_data2_i,
    input  logic [4:0]        write_reg_addr_i,
    input  logic [CTRL_W-1:0] control_signal_i,
    input  logic [31:0]       mem_write_data_i,
    output logic [31:0]       alu_result_o,
    output logic [4:0]        write_reg_addr_o,
    output logic [CTRL_W-1:0] control_signal_o,
    output logic [31:0]       mem_write_data_o,
    output logic              bpalu_write_reg_en_o,
    output logic              stall_req_o
);

    localparam logic [4:0] OP_ADD   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_AND   = 5'd3;
    localparam logic [4:0] OP_OR    = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_NOR   = 5'd6;
    localparam logic [4:0] OP_SLT   = 5'd7;
    localparam logic [4:0] OP_SLTU  = 5'd8;
    localparam logic [4:0] OP_SLL   = 5'd9;
    localparam logic [4:0] OP_SRL   = 5'd10;
    localparam logic [4:0] OP_SRA   = 5'd11;
    localparam logic [4:0] OP_LUI   = 5'd12;
    localparam logic [4:0] OP_MULT  = 5'd13;
    localparam logic [4:0] OP_MULTU = 5'd14;
    localparam logic [4:0] OP_DIV   = 5'd15;
    localparam logic [4:0] OP_DIVU  = 5'd16;
    localparam logic [4:0] OP_MFHI  = 5'd17;
    localparam logic [4:0] OP_MFLO  = 5'd18;
    localparam logic [4:0] OP_MTHI  = 5'd19;
    localparam logic [4:0] OP_MTLO  = 5'd20;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t  state, state_next;
    logic [31:0] hi, lo;
    logic [31:0] div_quo, div_rem, div_dvs;
    logic [4:0]  div_cnt;
    logic        div_qneg, div_rneg;

    logic        is_div, is_sdiv, div_by_zero;
    logic [31:0] abs_a, abs_b;
    logic [63:0] prod_s, prod_u;
    logic [32:0] trial;
    logic [31:0] quo_fix, rem_fix;

    assign is_div      = (alu_op_i == OP_DIV) || (alu_op_i == OP_DIVU);
    assign is_sdiv     = (alu_op_i == OP_DIV);
    assign div_by_zero = (src_data2_i == '0);
    assign abs_a = (is_sdiv && src_data1_i[31]) ? -src_data1_i : src_data1_i;
    assign abs_b = (is_sdiv && src_data2_i[31]) ? -src_data2_i : src_data2_i;

    // Lower 64 bits of the product of sign-extended operands is the signed product.
    assign prod_s = {{32{src_data1_i[31]}}, src_data1_i} * {{32{src_data2_i[31]}}, src_data2_i};
    assign prod_u = {32'h0, src_data1_i} * {32'h0, src_data2_i};

    // Quotient register starts as the dividend; its MSB shifts into the
    // partial remainder each step. A set trial[32] means restore.
    assign trial   = {div_rem, div_quo[31]} - {1'b0, div_dvs};
    assign quo_fix = div_qneg ? -div_quo : div_quo;
    assign rem_fix = div_rneg ? -div_rem : div_rem;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (is_div && !div_by_zero) state_next = BUSY;
            BUSY:    if (div_cnt == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: the issue cycle already stalls, DONE releases the pipeline
    always_comb begin
        stall_req_o = 1'b0;
        case (state)
            IDLE:    stall_req_o = is_div && !div_by_zero;
            BUSY:    stall_req_o = 1'b1;
            default: stall_req_o = 1'b0;
        endcase
    end

    // HI/LO and divider datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            div_quo  <= '0;
            div_rem  <= '0;
            div_dvs  <= '0;
            div_cnt  <= '0;
            div_qneg <= 1'b0;
            div_rneg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_div) begin
                        if (div_by_zero) begin
                            lo <= '1;
                            hi <= src_data1_i;
                        end else begin
                            div_quo  <= abs_a;
                            div_rem  <= '0;
                            div_dvs  <= abs_b;
                            div_cnt  <= '0;
                            div_qneg <= is_sdiv && (src_data1_i[31] ^ src_data2_i[31]);
                            div_rneg <= is_sdiv && src_data1_i[31];
                        end
                    end else begin
                        case (alu_op_i)
                            OP_MULT:  {hi, lo} <= prod_s;
                            OP_MULTU: {hi, lo} <= prod_u;
                            OP_MTHI:  hi <= src_data1_i;
                            OP_MTLO:  lo <= src_data1_i;
                            default:  ;
                        endcase
                    end
                end
                BUSY: begin
                    if (trial[32]) begin
                        div_rem <= {div_rem[30:0], div_quo[31]};
                        div_quo <= {div_quo[30:0], 1'b0};
                    end else begin
                        div_rem <= trial[31:0];
                        div_quo <= {div_quo[30:0], 1'b1};
                    end
                    div_cnt <= div_cnt + 5'd1;
                end
                DONE: begin
                    lo <= quo_fix;
                    hi <= rem_fix;
                end
                default: ;
            endcase
        end
    end

    // ALU result
    always_comb begin
        alu_result_o = '0;
        case (alu_op_i)
            OP_ADD:  alu_result_o = src_data1_i + src_data2_i;
            OP_SUB:  alu_result_o = src_data1_i - src_data2_i;
            OP_AND:  alu_result_o = src_data1_i & src_data2_i;
            OP_OR:   alu_result_o = src_data1_i | src_data2_i;
            OP_XOR:  alu_result_o = src_data1_i ^ src_data2_i;
            OP_NOR:  alu_result_o = ~(src_data1_i | src_data2_i);
            OP_SLT:  alu_result_o = {31'h0, $signed(src_data1_i) < $signed(src_data2_i)};
            OP_SLTU: alu_result_o = {31'h0, src_data1_i < src_data2_i};
            OP_SLL:  alu_result_o = src_data2_i << src_data1_i[4:0];
            OP_SRL:  alu_result_o = src_data2_i >> src_data1_i[4:0];
            OP_SRA:  alu_result_o = $signed(src_data2_i) >>> src_data1_i[4:0];
            OP_LUI:  alu_result_o = {src_data2_i[15:0], 16'h0};
            OP_MFHI: alu_result_o = hi;
            OP_MFLO: alu_result_o = lo;
            default: alu_result_o = '0;
        endcase
    end

    assign write_reg_addr_o     = write_reg_addr_i;
    assign mem_write_data_o     = mem_write_data_i;
    assign control_signal_o     = stall_req_o ? '0 : control_signal_i;
    assign bpalu_write_reg_en_o = control_signal_i[WE_BIT] & ~stall_req_o;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage. Expected values
// are pushed to a scoreboard queue as stimulus is driven and popped when
// the corresponding DUT output is sampled.
`timescale 1ns/1ps
module tb_ex_stage;

    localparam logic [4:0] NOP = 5'd0,  ADD = 5'd1,  SUB = 5'd2,   AND_ = 5'd3,
                           OR_ = 5'd4,  XOR_ = 5'd5, NOR_ = 5'd6,  SLT = 5'd7,
                           SLTU = 5'd8, SLL = 5'd9,  SRL = 5'd10,  SRA = 5'd11,
                           LUI = 5'd12, MULT = 5'd13, MULTU = 5'd14, DIV = 5'd15,
                           DIVU = 5'd16, MFHI = 5'd17, MFLO = 5'd18, MTHI = 5'd19,
                           MTLO = 5'd20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  alu_op = '0;
    logic [31:0] src1 = '0, src2 = '0;
    logic [4:0]  wr_addr = '0;
    logic [7:0]  ctrl = '0;
    logic [31:0] md = '0;
    logic [31:0] alu_result, md_out;
    logic [4:0]  wr_addr_out;
    logic [7:0]  ctrl_out;
    logic        bp_we, stall;

    logic [31:0] exp_q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    ex_stage #(.CTRL_W(8), .WE_BIT(0)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .alu_op_i             (alu_op),
        .src_data1_i          (src1),
        .src_data2_i          (src2),
        .write_reg_addr_i     (wr_addr),
        .control_signal_i     (ctrl),
        .mem_write_data_i     (md),
        .alu_result_o         (alu_result),
        .write_reg_addr_o     (wr_addr_out),
        .control_signal_o     (ctrl_out),
        .mem_write_data_o     (md_out),
        .bpalu_write_reg_en_o (bp_we),
        .stall_req_o          (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_op = op;
        src1   = a;
        src2   = b;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic alu_vec(input string tag, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        exp_q.push_back(exp);
        drive(op, a, b);
        check(tag, alu_result);
    endtask

    // Counts stalled cycles from the issue cycle; returns sampling the first
    // non-stalled cycle. Flags any enable/control leakage while stalled.
    task automatic wait_div(output int n, output logic leak);
        n = 0;
        leak = 1'b0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            if (bp_we !== 1'b0 || ctrl_out !== 8'h00) leak = 1'b1;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic div_vec(input string tag, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int   n;
        logic leak;
        exp_q.push_back(32'd33);
        exp_q.push_back(32'd0);
        drive(op, a, b);
        wait_div(n, leak);
        check({tag, "_stall_cycles"}, n);
        check({tag, "_we_leak"}, {31'h0, leak});
        alu_vec({tag, "_lo"}, MFLO, '0, '0, exp_lo);
        alu_vec({tag, "_hi"}, MFHI, '0, '0, exp_hi);
    endtask

    initial begin
        int   n1, n2;
        logic leak1, leak2;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        exp_q.push_back(32'd0);
        alu_vec("rst_hi", MFHI, '0, '0, 32'h0);
        check("rst_stall", {31'h0, stall});
        alu_vec("rst_lo", MFLO, '0, '0, 32'h0);

        // Pass-through with a non-stalling op
        wr_addr = 5'd17;
        ctrl    = 8'hA5;
        md      = 32'hDEADBEEF;
        exp_q.push_back(32'd17);
        exp_q.push_back(32'hA5);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'd1);
        drive(ADD, 32'd1, 32'd2);
        check("pt_waddr", {27'h0, wr_addr_out});
        check("pt_ctrl", {24'h0, ctrl_out});
        check("pt_mdata", md_out);
        check("pt_bpwe", {31'h0, bp_we});

        // Single-cycle ALU ops
        alu_vec("add_wrap", ADD,  32'h7FFFFFFF, 32'h1, 32'h80000000);
        alu_vec("sub_wrap", SUB,  32'h0, 32'h1, 32'hFFFFFFFF);
        alu_vec("and",      AND_, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        alu_vec("or",       OR_,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0);
        alu_vec("xor",      XOR_, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F);
        alu_vec("nor",      NOR_, 32'h0F0F0F0F, 32'hF0F00000, 32'h0000F0F0);
        alu_vec("slt",      SLT,  32'hFFFFFFFF, 32'h1, 32'h1);
        alu_vec("sltu",     SLTU, 32'hFFFFFFFF, 32'h1, 32'h0);
        alu_vec("sra",      SRA,  32'd4, 32'h80000000, 32'hF8000000);
        alu_vec("srl",      SRL,  32'd4, 32'h80000000, 32'h08000000);
        alu_vec("sll_mask", SLL,  32'h24, 32'h1, 32'h10);
        alu_vec("lui",      LUI,  32'h0, 32'h0001ABCD, 32'hABCD0000);
        alu_vec("nop",      NOP,  32'd5, 32'd6, 32'h0);
        alu_vec("op25_nop", 5'd25, 32'd5, 32'd6, 32'h0);

        // Multiplier and HI/LO moves
        alu_vec("mult_res",  MULT,  32'hFFFFFFFF, 32'h2, 32'h0);
        alu_vec("mult_hi",   MFHI,  '0, '0, 32'hFFFFFFFF);
        alu_vec("mult_lo",   MFLO,  '0, '0, 32'hFFFFFFFE);
        alu_vec("multu_res", MULTU, 32'hFFFFFFFF, 32'h2, 32'h0);
        alu_vec("multu_hi",  MFHI,  '0, '0, 32'h1);
        alu_vec("multu_lo",  MFLO,  '0, '0, 32'hFFFFFFFE);
        alu_vec("mthi_res",  MTHI,  32'h12345678, '0, 32'h0);
        alu_vec("mtlo_res",  MTLO,  32'h9ABCDEF0, '0, 32'h0);
        alu_vec("mt_hi",     MFHI,  '0, '0, 32'h12345678);
        alu_vec("mt_lo",     MFLO,  '0, '0, 32'h9ABCDEF0);

        // Signed divides
        div_vec("div_m7_2", DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        div_vec("div_7_m2", DIV, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1);

        // Divide by zero: no stall, LO all-ones, HI = dividend
        exp_q.push_back(32'd0);
        alu_vec("divz_res", DIVU, 32'd100, 32'd0, 32'h0);
        check("divz_stall", {31'h0, stall});
        alu_vec("divz_lo", MFLO, '0, '0, 32'hFFFFFFFF);
        alu_vec("divz_hi", MFHI, '0, '0, 32'd100);

        // Reset mid-divide aborts without HI/LO update
        drive(DIVU, 32'hFFFFFFFF, 32'd3);
        repeat (10) @(negedge clk);
        rst    = 1'b1;
        alu_op = NOP;
        src1   = '0;
        src2   = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.push_back(32'd0);
        check("rstabort_stall", {31'h0, stall});
        alu_vec("rstabort_hi", MFHI, '0, '0, 32'h0);
        alu_vec("rstabort_lo", MFLO, '0, '0, 32'h0);
        div_vec("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 32'd0);

        // Back-to-back divides separated by exactly one DONE cycle
        exp_q.push_back(32'd33);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd33);
        exp_q.push_back(32'd0);
        drive(DIVU, 32'd10, 32'd3);
        wait_div(n1, leak1);
        check("b2b_first_cycles", n1);
        drive(DIVU, 32'd20, 32'd6);
        check("b2b_second_issue_stall", {31'h0, stall});
        wait_div(n2, leak2);
        check("b2b_second_cycles", n2);
        check("b2b_we_leak", {31'h0, leak1 | leak2});
        alu_vec("b2b_lo", MFLO, '0, '0, 32'd3);
        alu_vec("b2b_hi", MFHI, '0, '0, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
